// File: rtl/icu_pkg.sv
// Shared opcode encodings and instruction-field helpers for the icu_core slice.
package icu_pkg;

  localparam logic [3:0] OP_NOPO = 4'h0;
  localparam logic [3:0] OP_LD   = 4'h1;
  localparam logic [3:0] OP_LDC  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_ANDC = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_ORC  = 4'h6;
  localparam logic [3:0] OP_XNOR = 4'h7;
  localparam logic [3:0] OP_STO  = 4'h8;
  localparam logic [3:0] OP_STOC = 4'h9;
  localparam logic [3:0] OP_IEN  = 4'hA;
  localparam logic [3:0] OP_OEN  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_RTN  = 4'hD;
  localparam logic [3:0] OP_SKZ  = 4'hE;
  localparam logic [3:0] OP_NOPF = 4'hF;
  localparam logic [3:0] OP_CALL = 4'hF;

  // Opcode sits directly above the addr_w-bit address field.
  function automatic logic [3:0] instr_op(input logic [31:0] word, input int unsigned addr_w);
    return 4'(word >> addr_w);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == OP_STO) || (op == OP_STOC);
  endfunction

endpackage

// File: rtl/icu_ret_stack.sv
// DEPTH x PC_W LIFO of return addresses; pushes when full and pops when empty are ignored.
module icu_ret_stack #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [PC_W-1:0] data_i,
  output logic            full_o,
  output logic            empty_o,
  output logic [PC_W-1:0] top_o
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PC_W-1:0]  mem_q [DEPTH];
  logic [SP_W-1:0]  sp_q;
  logic [SP_W-1:0]  sp_m1_s;
  logic [IDX_W-1:0] wr_idx_s;
  logic [IDX_W-1:0] rd_idx_s;

  assign sp_m1_s  = sp_q - 1'b1;
  assign wr_idx_s = sp_q[IDX_W-1:0];
  assign rd_idx_s = sp_m1_s[IDX_W-1:0];
  assign full_o   = (sp_q == SP_W'(DEPTH));
  assign empty_o  = (sp_q == '0);
  assign top_o    = mem_q[rd_idx_s];

  // Stack pointer counts occupied entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q <= '0;
    end else if (push_i && !full_o) begin
      sp_q <= sp_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      sp_q <= sp_m1_s;
    end else begin
      sp_q <= sp_q;
    end
  end

  // Entry storage written at the current pointer on push.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i && !full_o) begin
      mem_q[wr_idx_s] <= data_i;
    end
  end

endmodule

// File: rtl/icu_core.sv
// W-bit industrial control unit: addressed I/O, program counter, skip logic.
// Define ICU_CALLSTACK_EN to turn opcode F into CALL and give RTN a real return stack.
module icu_core
  import icu_pkg::*;
#(
  parameter int W      = 8,
  parameter int ADDR_W = 6,
  parameter int PC_W   = 6,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [ADDR_W+3:0] instr,
  output logic [PC_W-1:0]   pc,
  output logic [ADDR_W-1:0] io_addr,
  input  logic [W-1:0]      din,
  output logic [W-1:0]      dout,
  output logic              wr,
  output logic [W-1:0]      rr_o,
  output logic              flg0,
  output logic              flgf,
  output logic              jmp,
  output logic              rtn,
  output logic              ovf,
  output logic              unf
);

  logic [PC_W-1:0]   pc_q, pc_d, pc_inc_s, tgt_s;
  logic [W-1:0]      rr_q, rr_d, md_s;
  logic              ien_q, ien_d, oen_q, oen_d, skip_q, skip_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic [3:0]        op_s;
  logic [ADDR_W-1:0] addr_s;
  logic              exec_s;

  assign op_s     = instr_op(32'(instr), ADDR_W);
  assign addr_s   = instr[ADDR_W-1:0];
  assign tgt_s    = addr_s[PC_W-1:0];
  assign pc_inc_s = pc_q + 1'b1;
  assign exec_s   = instr_valid && !skip_q && !rst;
  assign md_s     = din & {W{ien_q}};

  assign pc      = pc_q;
  assign rr_o    = rr_q;
  assign io_addr = addr_s;
  assign ovf     = ovf_q;
  assign unf     = unf_q;

`ifdef ICU_CALLSTACK_EN
  logic            push_s, pop_s, full_s, empty_s;
  logic [PC_W-1:0] top_s;

  icu_ret_stack #(.DEPTH(DEPTH), .PC_W(PC_W)) u_ret_stack (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  (pc_inc_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .top_o   (top_s)
  );
`endif

  // Next-state decode; a skipped word only advances pc and clears skip.
  always_comb begin
    pc_d   = pc_q;
    rr_d   = rr_q;
    ien_d  = ien_q;
    oen_d  = oen_q;
    skip_d = skip_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
`ifdef ICU_CALLSTACK_EN
    push_s = 1'b0;
    pop_s  = 1'b0;
`endif
    if (instr_valid) begin
      pc_d   = pc_inc_s;
      skip_d = 1'b0;
      if (!skip_q) begin
        case (op_s)
          OP_LD:   rr_d = md_s;
          OP_LDC:  rr_d = ~md_s;
          OP_AND:  rr_d = rr_q & md_s;
          OP_ANDC: rr_d = rr_q & ~md_s;
          OP_OR:   rr_d = rr_q | md_s;
          OP_ORC:  rr_d = rr_q | ~md_s;
          OP_XNOR: rr_d = ~(rr_q ^ md_s);
          OP_IEN:  ien_d = din[0];
          OP_OEN:  oen_d = din[0];
          OP_JMP:  pc_d = tgt_s;
          OP_SKZ:  skip_d = (rr_q == '0);
`ifdef ICU_CALLSTACK_EN
          OP_RTN: begin
            if (empty_s) begin
              unf_d = 1'b1;
            end else begin
              pop_s  = 1'b1;
              pc_d   = top_s;
              skip_d = 1'b1;
            end
          end
          OP_CALL: begin
            if (full_s) begin
              ovf_d = 1'b1;
            end else begin
              push_s = 1'b1;
              pc_d   = tgt_s;
            end
          end
`else
          OP_RTN:  skip_d = 1'b1;
`endif
          default: pc_d = pc_inc_s;
        endcase
      end else begin
        skip_d = 1'b0;
      end
    end else begin
      pc_d = pc_q;
    end
  end

  // Architectural state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= '0;
      rr_q   <= '0;
      ien_q  <= 1'b0;
      oen_q  <= 1'b0;
      skip_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      rr_q   <= rr_d;
      ien_q  <= ien_d;
      oen_q  <= oen_d;
      skip_q <= skip_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  // Strobes, pulses and store data for the word currently presented.
  always_comb begin
    flg0 = exec_s && (op_s == OP_NOPO);
`ifdef ICU_CALLSTACK_EN
    flgf = 1'b0;
`else
    flgf = exec_s && (op_s == OP_NOPF);
`endif
    jmp  = exec_s && (op_s == OP_JMP);
    rtn  = exec_s && (op_s == OP_RTN);
    wr   = exec_s && oen_q && op_is_store(op_s);
    case (op_s)
      OP_STO:  dout = rr_q;
      OP_STOC: dout = ~rr_q;
      default: dout = '0;
    endcase
  end

endmodule

// File: tb/tb_icu_core.sv
// Self-checking bench for icu_core: directed scenarios plus a randomized run against a queue-based model.
module tb_icu_core;

  localparam int W = 8, ADDR_W = 6, PC_W = 6, DEPTH = 2;
  localparam int PC_MOD = 64;
`ifdef ICU_CALLSTACK_EN
  localparam bit STACK = 1'b1;
`else
  localparam bit STACK = 1'b0;
`endif

  logic              clk, rst, instr_valid;
  logic [ADDR_W+3:0] instr;
  logic [PC_W-1:0]   pc;
  logic [ADDR_W-1:0] io_addr;
  logic [W-1:0]      din, dout, rr_o;
  logic              wr, flg0, flgf, jmp, rtn, ovf, unf;

  icu_core #(.W(W), .ADDR_W(ADDR_W), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .pc(pc),
    .io_addr(io_addr), .din(din), .dout(dout), .wr(wr), .rr_o(rr_o),
    .flg0(flg0), .flgf(flgf), .jmp(jmp), .rtn(rtn), .ovf(ovf), .unf(unf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // reference model state
  int         m_pc;
  logic [7:0] m_rr;
  bit         m_ien, m_oen, m_skip, m_ovf, m_unf;
  int         stk[$];

  // expected / observed combinational outputs of the last stepped word
  logic       e_wr, e_flg0, e_flgf, e_jmp, e_rtn;
  logic [7:0] e_dout;
  logic [5:0] e_io;
  logic       o_wr, o_flg0, o_flgf, o_jmp, o_rtn;
  logic [7:0] o_dout;
  logic [5:0] o_io;

  function automatic void model_reset();
    m_pc = 0; m_rr = 8'h00;
    m_ien = 1'b0; m_oen = 1'b0; m_skip = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    stk.delete();
  endfunction

  function automatic void model_exec(input logic [3:0] op, input logic [5:0] a, input logic [7:0] d);
    logic [7:0] md;
    bit was_skip;
    was_skip = m_skip;
    m_pc = (m_pc + 1) % PC_MOD;
    m_skip = 1'b0;
    if (was_skip) return;
    md = m_ien ? d : 8'h00;
    case (op)
      4'h1: m_rr = md;
      4'h2: m_rr = ~md;
      4'h3: m_rr = m_rr & md;
      4'h4: m_rr = m_rr & ~md;
      4'h5: m_rr = m_rr | md;
      4'h6: m_rr = m_rr | ~md;
      4'h7: m_rr = ~(m_rr ^ md);
      4'hA: m_ien = d[0];
      4'hB: m_oen = d[0];
      4'hC: m_pc = int'(a) % PC_MOD;
      4'hD: begin
        if (!STACK) m_skip = 1'b1;
        else if (stk.size() == 0) m_unf = 1'b1;
        else begin m_pc = stk.pop_back(); m_skip = 1'b1; end
      end
      4'hE: m_skip = (m_rr == 8'h00);
      4'hF: begin
        if (STACK) begin
          if (stk.size() == DEPTH) m_ovf = 1'b1;
          else begin stk.push_back(m_pc); m_pc = int'(a) % PC_MOD; end
        end
      end
      default: ;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Present one word for one cycle, capture mid-cycle outputs, then advance the model.
  task automatic step(input bit v, input logic [3:0] op, input logic [5:0] a, input logic [7:0] d);
    bit ex;
    @(negedge clk);
    instr_valid = v; instr = {op, a}; din = d;
    #1;
    ex     = v && !m_skip;
    e_wr   = ex && m_oen && (op == 4'h8 || op == 4'h9);
    e_dout = (op == 4'h8) ? m_rr : (op == 4'h9) ? ~m_rr : 8'h00;
    e_io   = a;
    e_flg0 = ex && op == 4'h0;
    e_flgf = ex && op == 4'hF && !STACK;
    e_jmp  = ex && op == 4'hC;
    e_rtn  = ex && op == 4'hD;
    o_wr = wr; o_dout = dout; o_io = io_addr;
    o_flg0 = flg0; o_flgf = flgf; o_jmp = jmp; o_rtn = rtn;
    @(posedge clk);
    #1;
    if (v) model_exec(op, a, d);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc !== 6'd0)   begin errors++; $display("FAIL reset_pc: got %0d expected 0", pc); end
    checks++; if (rr_o !== 8'h00) begin errors++; $display("FAIL reset_rr: got %h expected 00", rr_o); end
    checks++; if (ovf !== 1'b0 || unf !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovf=%b unf=%b expected 0 0", ovf, unf); end
    step(1'b1, 4'hA, 6'd0, 8'h01);
    step(1'b1, 4'h1, 6'd0, 8'h5A);
    step(1'b1, 4'hA, 6'd0, 8'h00);
    step(1'b1, 4'h1, 6'd0, 8'hFF);
    step(1'b1, 4'hE, 6'd0, 8'h00);
    @(negedge clk);
    rst = 1'b1; instr_valid = 1'b1; instr = {4'h0, 6'd0};
    #1;
    checks++; if (flg0 !== 1'b0) begin errors++; $display("FAIL reset_pulse: got flg0=%b expected 0", flg0); end
    @(posedge clk); #1;
    checks++; if (pc !== 6'd0) begin errors++; $display("FAIL reset_mid_pc: got %0d expected 0", pc); end
    @(negedge clk);
    rst = 1'b0; instr_valid = 1'b0;
    model_reset();
    step(1'b1, 4'h0, 6'd0, 8'h00);
    checks++; if (o_flg0 !== 1'b1) begin errors++; $display("FAIL reset_clears_skip: got flg0=%b expected 1", o_flg0); end
  endtask

  task automatic test_store();
    do_reset();
    step(1'b1, 4'hA, 6'd0, 8'h01);
    step(1'b1, 4'h1, 6'd3, 8'hA5);
    step(1'b1, 4'hB, 6'd0, 8'h01);
    step(1'b1, 4'h8, 6'd7, 8'h00);
    checks++; if (o_wr !== 1'b1)  begin errors++; $display("FAIL sto_wr: got %b expected 1", o_wr); end
    checks++; if (o_io !== 6'd7)  begin errors++; $display("FAIL sto_io_addr: got %0d expected 7", o_io); end
    checks++; if (o_dout !== 8'hA5) begin errors++; $display("FAIL sto_dout: got %h expected a5", o_dout); end
    checks++; if (rr_o !== 8'hA5) begin errors++; $display("FAIL sto_rr: got %h expected a5", rr_o); end
    step(1'b1, 4'h9, 6'd9, 8'h00);
    checks++; if (o_dout !== 8'h5A || o_wr !== 1'b1) begin errors++; $display("FAIL stoc: got dout=%h wr=%b expected 5a 1", o_dout, o_wr); end
    checks++; if (pc !== 6'd5) begin errors++; $display("FAIL sto_pc: got %0d expected 5", pc); end
  endtask

  task automatic test_skz();
    logic [5:0] pc0;
    do_reset();
    step(1'b1, 4'hA, 6'd0, 8'h00);
    step(1'b1, 4'h1, 6'd0, 8'hFF);
    checks++; if (rr_o !== 8'h00) begin errors++; $display("FAIL mask_ld: got %h expected 00", rr_o); end
    pc0 = pc;
    step(1'b1, 4'hE, 6'd0, 8'h00);
    step(1'b1, 4'h1, 6'd0, 8'h01);
    checks++; if (rr_o !== 8'h00) begin errors++; $display("FAIL skz_discard: got %h expected 00", rr_o); end
    checks++; if (pc !== 6'(pc0 + 6'd2)) begin errors++; $display("FAIL skz_pc: got %0d expected %0d", pc, 6'(pc0 + 6'd2)); end
  endtask

  task automatic test_logic();
    do_reset();
    step(1'b1, 4'hA, 6'd0, 8'h01);
    step(1'b1, 4'h1, 6'd0, 8'h0F);
    step(1'b1, 4'h7, 6'd0, 8'h3C);
    checks++; if (rr_o !== 8'hCC) begin errors++; $display("FAIL xnor: got %h expected cc", rr_o); end
    step(1'b1, 4'h6, 6'd0, 8'hF0);
    checks++; if (rr_o !== 8'hCF) begin errors++; $display("FAIL orc: got %h expected cf", rr_o); end
  endtask

  task automatic test_stall();
    logic [5:0] pc0;
    logic [7:0] rr0;
    do_reset();
    step(1'b1, 4'hA, 6'd0, 8'h01);
    step(1'b1, 4'hB, 6'd0, 8'h01);
    step(1'b1, 4'h1, 6'd0, 8'h00);
    step(1'b1, 4'hE, 6'd0, 8'h00);
    pc0 = pc; rr0 = rr_o;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'h8, 6'(i), 8'($urandom));
      checks++; if (o_wr !== 1'b0) begin errors++; $display("FAIL stall_wr: got %b expected 0", o_wr); end
      checks++; if (pc !== pc0 || rr_o !== rr0) begin errors++; $display("FAIL stall_hold: got pc=%0d rr=%h expected %0d %h", pc, rr_o, pc0, rr0); end
    end
    step(1'b1, 4'h1, 6'd0, 8'h55);
    checks++; if (rr_o !== 8'h00) begin errors++; $display("FAIL stall_skip_kept: got %h expected 00", rr_o); end
    checks++; if (pc !== 6'(pc0 + 6'd1)) begin errors++; $display("FAIL stall_resume_pc: got %0d expected %0d", pc, 6'(pc0 + 6'd1)); end
  endtask

`ifdef ICU_CALLSTACK_EN
  task automatic test_callstack();
    do_reset();
    step(1'b1, 4'h0, 6'd0, 8'h00);
    step(1'b1, 4'hF, 6'd10, 8'h00);
    step(1'b1, 4'hF, 6'd20, 8'h00);
    checks++; if (pc !== 6'd20) begin errors++; $display("FAIL call_pc: got %0d expected 20", pc); end
    step(1'b1, 4'hF, 6'd30, 8'h00);
    checks++; if (pc !== 6'd21 || ovf !== 1'b1) begin errors++; $display("FAIL call_ovf: got pc=%0d ovf=%b expected 21 1", pc, ovf); end
    checks++; if (o_flgf !== 1'b0) begin errors++; $display("FAIL call_flgf: got %b expected 0", o_flgf); end
    step(1'b1, 4'hD, 6'd0, 8'h00);
    checks++; if (pc !== 6'd11 || o_rtn !== 1'b1) begin errors++; $display("FAIL rtn1: got pc=%0d rtn=%b expected 11 1", pc, o_rtn); end
    step(1'b1, 4'h0, 6'd0, 8'h00);
    checks++; if (o_flg0 !== 1'b0 || pc !== 6'd12) begin errors++; $display("FAIL rtn_skip: got flg0=%b pc=%0d expected 0 12", o_flg0, pc); end
    step(1'b1, 4'hD, 6'd0, 8'h00);
    checks++; if (pc !== 6'd2) begin errors++; $display("FAIL rtn2: got %0d expected 2", pc); end
    step(1'b1, 4'h0, 6'd0, 8'h00);
    step(1'b1, 4'hD, 6'd0, 8'h00);
    checks++; if (unf !== 1'b1 || pc !== 6'd4) begin errors++; $display("FAIL rtn_unf: got unf=%b pc=%0d expected 1 4", unf, pc); end
  endtask
`else
  task automatic test_nopf_rtn();
    do_reset();
    step(1'b1, 4'hF, 6'd17, 8'h00);
    checks++; if (o_flgf !== 1'b1 || pc !== 6'd1) begin errors++; $display("FAIL nopf: got flgf=%b pc=%0d expected 1 1", o_flgf, pc); end
    step(1'b1, 4'hA, 6'd0, 8'h01);
    step(1'b1, 4'h1, 6'd0, 8'h33);
    step(1'b1, 4'hD, 6'd0, 8'h00);
    checks++; if (o_rtn !== 1'b1 || pc !== 6'd4) begin errors++; $display("FAIL rtn_plain: got rtn=%b pc=%0d expected 1 4", o_rtn, pc); end
    step(1'b1, 4'h1, 6'd0, 8'h77);
    checks++; if (rr_o !== 8'h33 || pc !== 6'd5) begin errors++; $display("FAIL rtn_skip: got rr=%h pc=%0d expected 33 5", rr_o, pc); end
    checks++; if (ovf !== 1'b0 || unf !== 1'b0) begin errors++; $display("FAIL no_stack_flags: got ovf=%b unf=%b expected 0 0", ovf, unf); end
  endtask
`endif

  task automatic test_random();
    bit v;
    logic [3:0] op;
    logic [5:0] a;
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 9) != 0);
      op = 4'($urandom);
      a  = 6'($urandom);
      d  = 8'($urandom);
      step(v, op, a, d);
      checks++; if (o_wr !== e_wr || o_dout !== e_dout || o_io !== e_io) begin errors++;
        $display("FAIL rnd_io[%0d]: got wr=%b dout=%h addr=%0d expected %b %h %0d", i, o_wr, o_dout, o_io, e_wr, e_dout, e_io); end
      checks++; if ({o_flg0, o_flgf, o_jmp, o_rtn} !== {e_flg0, e_flgf, e_jmp, e_rtn}) begin errors++;
        $display("FAIL rnd_pulses[%0d]: got %b expected %b", i, {o_flg0, o_flgf, o_jmp, o_rtn}, {e_flg0, e_flgf, e_jmp, e_rtn}); end
      checks++; if (pc !== 6'(m_pc) || rr_o !== m_rr) begin errors++;
        $display("FAIL rnd_state[%0d]: got pc=%0d rr=%h expected %0d %h", i, pc, rr_o, m_pc, m_rr); end
      checks++; if (ovf !== m_ovf || unf !== m_unf) begin errors++;
        $display("FAIL rnd_flags[%0d]: got ovf=%b unf=%b expected %b %b", i, ovf, unf, m_ovf, m_unf); end
    end
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0; din = '0;
    model_reset();
    test_reset();
    test_store();
    test_skz();
    test_logic();
    test_stall();
`ifdef ICU_CALLSTACK_EN
    test_callstack();
`else
    test_nopf_rtn();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
